write_back_stage: RTL and testbench

- Final (WB) pipeline stage of the RISC-V integer+float core.
- Registers MEM/WB results and selects the write value by ResultSrc.
- Drives the single shared register-file write port (WA, WB, integer enable WE, float enable WEF) consumed by the decode stage.
- Merges asynchronous results from the long-latency FPU unit (fdiv/fsqrt) into that port through a one-entry hold buffer with a valid/ready handshake.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_hold_buffer.sv | 89 ++++++++
 rtl/write_back_stage.sv | 132 +++++++++++++
 tb/tb_write_back_stage.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the write-back stage: result-source encodings,
// hold-buffer FSM states and default widths.
package wb_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RAW_DEF  = 5;

  typedef enum logic [1:0] {
    RS_ALU  = 2'b00,
    RS_LOAD = 2'b01,
    RS_PC4  = 2'b10,
    RS_FPU  = 2'b11
  } result_src_e;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'b00,
    WB_HOLD  = 2'b01,
    WB_FORCE = 2'b10
  } wb_state_e;

endpackage

// File: rtl/wb_hold_buffer.sv
// One-entry hold buffer for long-latency FPU results, with a wait counter
// that escalates to a pipeline-bubble request when the port stays busy.
module wb_hold_buffer
  import wb_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int RAW      = RAW_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pw_i,
  input  logic            fpu_valid_i,
  input  logic [RAW-1:0]  fpu_rd_i,
  input  logic [XLEN-1:0] fpu_data_i,
  input  logic            fpu_is_float_i,
  output logic            full_o,
  output logic            drain_o,
  output logic            stall_req_o,
  output logic            fpu_ready_o,
  output logic [RAW-1:0]  buf_rd_o,
  output logic [XLEN-1:0] buf_data_o,
  output logic            buf_is_float_o
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  wb_state_e       state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [RAW-1:0]  rd_q;
  logic [XLEN-1:0] data_q;
  logic            flt_q;
  logic            accept;

  assign full_o         = (state_q != WB_IDLE);
  assign drain_o        = full_o & ~pw_i;
  assign fpu_ready_o    = ~full_o | drain_o;
  assign accept         = fpu_valid_i & fpu_ready_o;
  assign stall_req_o    = (state_q == WB_FORCE);
  assign buf_rd_o       = rd_q;
  assign buf_data_o     = data_q;
  assign buf_is_float_o = flt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WB_IDLE: begin
        if (accept) begin
          state_d = WB_HOLD;
          cnt_d   = 4'd0;
        end
      end
      WB_HOLD, WB_FORCE: begin
        if (drain_o) begin
          // A same-cycle refill restarts the wait from zero.
          state_d = accept ? WB_HOLD : WB_IDLE;
          cnt_d   = 4'd0;
        end else if (state_q == WB_HOLD) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q + 4'd1 == MAX_W) state_d = WB_FORCE;
        end
      end
      default: begin
        state_d = WB_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= WB_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      rd_q   <= fpu_rd_i;
      data_q <= fpu_data_i;
      flt_q  <= fpu_is_float_i;
    end
  end

endmodule

// File: rtl/write_back_stage.sv
// WB stage: MEM/WB register, result select, and arbitration of the shared
// register-file write port with the FPU hold buffer. Optional: WB_FORWARD_EN.
module write_back_stage
  import wb_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int RAW      = RAW_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            mem_valid,
  input  logic [1:0]      mem_ResultSrc,
  input  logic            mem_RegWrite,
  input  logic            mem_RegWriteF,
  input  logic [RAW-1:0]  mem_rd,
  input  logic [XLEN-1:0] mem_alu,
  input  logic [XLEN-1:0] mem_load,
  input  logic [XLEN-1:0] mem_pc4,
  input  logic [XLEN-1:0] mem_fpu,
  input  logic            fpu_valid,
  output logic            fpu_ready,
  input  logic [RAW-1:0]  fpu_rd,
  input  logic [XLEN-1:0] fpu_data,
  input  logic            fpu_is_float,
  output logic            stall_req,
`ifdef WB_FORWARD_EN
  output logic            fwd_valid,
  output logic [RAW-1:0]  fwd_rd,
  output logic [XLEN-1:0] fwd_data,
  output logic            fwd_is_float,
`endif
  output logic [RAW-1:0]  WA,
  output logic [XLEN-1:0] WB,
  output logic            WE,
  output logic            WEF
);

  logic            valid_q, valid_d;
  logic            rw_q, rwf_q;
  logic [RAW-1:0]  rd_q;
  logic [XLEN-1:0] result_q, result_d;
  logic            pw;
  logic            buf_full, buf_drain;
  logic [RAW-1:0]  buf_rd;
  logic [XLEN-1:0] buf_data;
  logic            buf_flt;

  always_comb begin
    result_d = mem_alu;
    case (result_src_e'(mem_ResultSrc))
      RS_ALU:  result_d = mem_alu;
      RS_LOAD: result_d = mem_load;
      RS_PC4:  result_d = mem_pc4;
      RS_FPU:  result_d = mem_fpu;
      default: result_d = mem_alu;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    if (flush)      valid_d = 1'b0;
    else if (!stall) valid_d = mem_valid;
  end

  // MEM -> WB stage register
  always_ff @(posedge clk) begin
    if (!rst_n) valid_q <= 1'b0;
    else        valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      rw_q     <= mem_RegWrite;
      rwf_q    <= mem_RegWriteF;
      rd_q     <= mem_rd;
      result_q <= result_d;
    end
  end

  assign pw = valid_q & (rw_q | rwf_q);

  wb_hold_buffer #(
    .XLEN     (XLEN),
    .RAW      (RAW),
    .MAX_WAIT (MAX_WAIT)
  ) u_hold (
    .clk            (clk),
    .rst_n          (rst_n),
    .pw_i           (pw),
    .fpu_valid_i    (fpu_valid),
    .fpu_rd_i       (fpu_rd),
    .fpu_data_i     (fpu_data),
    .fpu_is_float_i (fpu_is_float),
    .full_o         (buf_full),
    .drain_o        (buf_drain),
    .stall_req_o    (stall_req),
    .fpu_ready_o    (fpu_ready),
    .buf_rd_o       (buf_rd),
    .buf_data_o     (buf_data),
    .buf_is_float_o (buf_flt)
  );

  // Pipeline owns the port whenever it writes; float wins over integer.
  always_comb begin
    WA  = '0;
    WB  = '0;
    WE  = 1'b0;
    WEF = 1'b0;
    if (pw) begin
      WA  = rd_q;
      WB  = result_q;
      WEF = rwf_q;
      WE  = rw_q & ~rwf_q & (rd_q != '0);
    end else if (buf_drain) begin
      WA  = buf_rd;
      WB  = buf_data;
      WEF = buf_flt;
      WE  = ~buf_flt & (buf_rd != '0);
    end
  end

`ifdef WB_FORWARD_EN
  assign fwd_valid    = WE | WEF;
  assign fwd_rd       = WA;
  assign fwd_data     = WB;
  assign fwd_is_float = WEF;
`endif

endmodule

// File: tb/tb_write_back_stage.sv
// Self-checking bench for write_back_stage: vector table, directed corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_write_back_stage;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, mem_valid;
  logic [1:0]  mem_ResultSrc;
  logic        mem_RegWrite, mem_RegWriteF;
  logic [4:0]  mem_rd;
  logic [31:0] mem_alu, mem_load, mem_pc4, mem_fpu;
  logic        fpu_valid, fpu_ready, fpu_is_float, stall_req;
  logic [4:0]  fpu_rd, WA;
  logic [31:0] fpu_data, WB;
  logic        WE, WEF;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  write_back_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_ResultSrc(mem_ResultSrc),
    .mem_RegWrite(mem_RegWrite), .mem_RegWriteF(mem_RegWriteF),
    .mem_rd(mem_rd), .mem_alu(mem_alu), .mem_load(mem_load),
    .mem_pc4(mem_pc4), .mem_fpu(mem_fpu),
    .fpu_valid(fpu_valid), .fpu_ready(fpu_ready), .fpu_rd(fpu_rd),
    .fpu_data(fpu_data), .fpu_is_float(fpu_is_float),
    .stall_req(stall_req), .WA(WA), .WB(WB), .WE(WE), .WEF(WEF)
  );

  // Reference model: stage contents, FIFO-of-one buffer and its age.
  typedef struct { logic [4:0] rd; logic [31:0] data; logic flt; } fent_t;
  fent_t       mbuf[$];
  int          age = 0;
  logic        m_valid = 1'b0, m_rw = 1'b0, m_rwf = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_res = '0;
  logic [4:0]  e_wa;
  logic [31:0] e_wb;
  logic        e_we, e_wef, e_ready, e_stall;

  task automatic model_expect();
    logic pwm;
    pwm = m_valid && (m_rw || m_rwf);
    e_wa = '0; e_wb = '0; e_we = 1'b0; e_wef = 1'b0;
    if (pwm) begin
      e_wa = m_rd; e_wb = m_res; e_wef = m_rwf;
      e_we = m_rw && !m_rwf && (m_rd != 0);
    end else if (mbuf.size() > 0) begin
      e_wa = mbuf[0].rd; e_wb = mbuf[0].data; e_wef = mbuf[0].flt;
      e_we = !mbuf[0].flt && (mbuf[0].rd != 0);
    end
    e_ready = (mbuf.size() == 0) || !pwm;
    e_stall = (mbuf.size() > 0) && (age >= MAXW);
  endtask

  task automatic model_edge();
    logic drained;
    fent_t e;
    model_expect();
    if (!rst_n) begin
      m_valid = 1'b0; mbuf.delete(); age = 0;
      return;
    end
    drained = (mbuf.size() > 0) && e_ready;
    if (flush) m_valid = 1'b0;
    else if (!stall) begin
      m_valid = mem_valid; m_rw = mem_RegWrite; m_rwf = mem_RegWriteF; m_rd = mem_rd;
      m_res = (mem_ResultSrc == 2'd0) ? mem_alu : (mem_ResultSrc == 2'd1) ? mem_load :
              (mem_ResultSrc == 2'd2) ? mem_pc4 : mem_fpu;
    end
    if (drained) void'(mbuf.pop_front());
    else if (mbuf.size() > 0) age++;
    if (fpu_valid && e_ready) begin
      e.rd = fpu_rd; e.data = fpu_data; e.flt = fpu_is_float;
      mbuf.push_back(e);
      age = 0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_port(input string tag, input logic [4:0] wa, input logic [31:0] wb,
                            input logic we, input logic wef);
    check({tag, ".WA"}, 64'(WA), 64'(wa));
    check({tag, ".WB"}, 64'(WB), 64'(wb));
    check({tag, ".WE"}, 64'(WE), 64'(we));
    check({tag, ".WEF"}, 64'(WEF), 64'(wef));
  endtask

  task automatic set_mem(input logic v, input logic [1:0] rs, input logic rw, input logic rwf,
                         input logic [4:0] rd, input logic [31:0] val);
    mem_valid = v; mem_ResultSrc = rs; mem_RegWrite = rw; mem_RegWriteF = rwf; mem_rd = rd;
    mem_alu = val; mem_load = ~val; mem_pc4 = val ^ 32'h5555_0000; mem_fpu = val + 32'd7;
  endtask

  typedef struct {
    logic [1:0] rs; logic rw; logic rwf; logic [4:0] rd;
    logic [31:0] alu; logic [31:0] load; logic [31:0] pc4; logic [31:0] fpu;
    logic [4:0] ewa; logic [31:0] ewb; logic ewe; logic ewef;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{2'b01, 1'b1, 1'b0, 5'd5,  32'h1, 32'hDEADBEEF, 32'h2, 32'h3, 5'd5,  32'hDEADBEEF, 1'b1, 1'b0};
    vecs[1] = '{2'b00, 1'b1, 1'b0, 5'd0,  32'h12, 32'h0, 32'h0, 32'h0,      5'd0,  32'h12,       1'b0, 1'b0};
    vecs[2] = '{2'b00, 1'b0, 1'b1, 5'd0,  32'h12, 32'h0, 32'h0, 32'h0,      5'd0,  32'h12,       1'b0, 1'b1};
    vecs[3] = '{2'b10, 1'b1, 1'b0, 5'd31, 32'h9, 32'h8, 32'h1004, 32'h7,    5'd31, 32'h1004,     1'b1, 1'b0};
    vecs[4] = '{2'b11, 1'b1, 1'b1, 5'd7,  32'h9, 32'h8, 32'h4, 32'h3F800000, 5'd7, 32'h3F800000, 1'b0, 1'b1};
    vecs[5] = '{2'b00, 1'b0, 1'b0, 5'd9,  32'hAB, 32'h8, 32'h4, 32'h3,      5'd0,  32'h0,        1'b0, 1'b0};

    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    set_mem(1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 32'h0);
    fpu_valid = 1'b0; fpu_rd = '0; fpu_data = '0; fpu_is_float = 1'b0;
    @(posedge clk); #1;
    tick(); tick();
    rst_n = 1'b1;
    check_port("reset", 5'd0, 32'h0, 1'b0, 1'b0);
    check("reset.stall_req", 64'(stall_req), 64'd0);
    check("reset.fpu_ready", 64'(fpu_ready), 64'd1);

    for (int i = 0; i < 6; i++) begin
      mem_valid = 1'b1; mem_ResultSrc = vecs[i].rs; mem_RegWrite = vecs[i].rw;
      mem_RegWriteF = vecs[i].rwf; mem_rd = vecs[i].rd; mem_alu = vecs[i].alu;
      mem_load = vecs[i].load; mem_pc4 = vecs[i].pc4; mem_fpu = vecs[i].fpu;
      tick();
      check_port($sformatf("vec%0d", i), vecs[i].ewa, vecs[i].ewb, vecs[i].ewe, vecs[i].ewef);
      mem_valid = 1'b0;
      tick();
    end

    // FPU result accepted while the pipeline is idle, drained next cycle.
    fpu_valid = 1'b1; fpu_rd = 5'd3; fpu_data = 32'h40490FDB; fpu_is_float = 1'b1;
    check("fpu.ready_idle", 64'(fpu_ready), 64'd1);
    tick();
    fpu_valid = 1'b0;
    check_port("fpu.drain", 5'd3, 32'h40490FDB, 1'b0, 1'b1);
    tick();
    check_port("fpu.after", 5'd0, 32'h0, 1'b0, 1'b0);

    // Buffer blocked by back-to-back pipeline writes until FORCE.
    set_mem(1'b1, 2'b00, 1'b1, 1'b0, 5'd1, 32'h100);
    fpu_valid = 1'b1; fpu_rd = 5'd4; fpu_data = 32'h0000A5A5; fpu_is_float = 1'b0;
    tick();
    fpu_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("force.c%0d.ready", k), 64'(fpu_ready), 64'd0);
      check($sformatf("force.c%0d.stall_req", k), 64'(stall_req), 64'(k == 5));
      check($sformatf("force.c%0d.WE", k), 64'(WE), 64'd1);
      if (k == 5) mem_valid = 1'b0;
      else mem_alu = 32'h100 + 32'(k);
      tick();
    end
    check_port("force.drain", 5'd4, 32'h0000A5A5, 1'b1, 1'b0);
    check("force.drain.ready", 64'(fpu_ready), 64'd1);
    tick();
    check("force.after.stall_req", 64'(stall_req), 64'd0);
    check_port("force.after", 5'd0, 32'h0, 1'b0, 1'b0);

    // Stall holds the stage; flush beats stall.
    set_mem(1'b1, 2'b00, 1'b1, 1'b0, 5'd8, 32'h88);
    tick();
    stall = 1'b1; set_mem(1'b1, 2'b00, 1'b1, 1'b0, 5'd9, 32'h99);
    tick();
    check_port("stall.hold", 5'd8, 32'h88, 1'b1, 1'b0);
    flush = 1'b1;
    tick();
    check_port("flush_stall", 5'd0, 32'h0, 1'b0, 1'b0);
    flush = 1'b0; stall = 1'b0; mem_valid = 1'b0;
    tick();

    // Reset during HOLD discards the buffered result.
    set_mem(1'b1, 2'b00, 1'b1, 1'b0, 5'd2, 32'h22);
    fpu_valid = 1'b1; fpu_rd = 5'd10; fpu_data = 32'h77; fpu_is_float = 1'b0;
    tick();
    fpu_valid = 1'b0;
    check("hold.ready", 64'(fpu_ready), 64'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; mem_valid = 1'b0;
    check_port("rst_hold", 5'd0, 32'h0, 1'b0, 1'b0);
    check("rst_hold.ready", 64'(fpu_ready), 64'd1);
    check("rst_hold.stall_req", 64'(stall_req), 64'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("rst_hold.nowrite%0d", k), 64'(WE | WEF), 64'd0);
    end

    // Randomized traffic against the reference model.
    for (int c = 0; c < 1500; c++) begin
      logic xfer;
      model_expect();
      check("rnd.WA", 64'(WA), 64'(e_wa));
      check("rnd.WB", 64'(WB), 64'(e_wb));
      check("rnd.WE", 64'(WE), 64'(e_we));
      check("rnd.WEF", 64'(WEF), 64'(e_wef));
      check("rnd.ready", 64'(fpu_ready), 64'(e_ready));
      check("rnd.stall_req", 64'(stall_req), 64'(e_stall));
      rst_n = ($urandom_range(0, 299) != 0);
      if (e_stall) begin
        stall = 1'b0; flush = 1'b0; mem_valid = 1'b0;
      end else begin
        stall = ($urandom_range(0, 7) == 0);
        flush = ($urandom_range(0, 15) == 0);
        set_mem($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                5'($urandom_range(0, 31)), $urandom());
      end
      if (!fpu_valid && $urandom_range(0, 2) == 0) begin
        fpu_valid = 1'b1; fpu_rd = 5'($urandom_range(0, 31));
        fpu_data = $urandom(); fpu_is_float = 1'($urandom_range(0, 1));
      end
      xfer = fpu_valid && e_ready;
      if (!rst_n) xfer = 1'b1;
      tick();
      if (xfer) fpu_valid = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
